// File: rtl/cache_set_nway.sv
// cache_set_nway: one N-way set of a byte-addressable cache with refill.
//
// A request is accepted in IDLE, looked up against all ways in LOOKUP, and
// either answered (RESP) or refilled from the next level (REFILL). After a
// refill the request is replayed through LOOKUP, where it hits.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE without inval)
//   req_write           1 = byte store, 0 = byte load
//   req_tag/req_offset  request address; req_wdata is the store byte
//   rsp_valid/rsp_hit   one-cycle response pulse; hit = served without refill
//   rsp_rdata           loaded byte, or the stored byte for a store
//   mem_req/mem_tag     refill request, held until mem_ack
//   mem_ack/mem_data    refill block (byte 0 in bits [7:0])
//   inval               clear every valid bit (honoured in IDLE only)
//   hit_cnt/miss_cnt    saturating event counters
module cache_set_nway #(
  parameter int WAYS     = 8,
  parameter int TAG_W    = 24,
  parameter int OFFSET_W = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic                           req_write,
  input  logic [TAG_W-1:0]               req_tag,
  input  logic [OFFSET_W-1:0]            req_offset,
  input  logic [7:0]                     req_wdata,
  output logic                           req_ready,
  output logic                           rsp_valid,
  output logic                           rsp_hit,
  output logic [7:0]                     rsp_rdata,
  output logic                           mem_req,
  output logic [TAG_W-1:0]               mem_tag,
  input  logic                           mem_ack,
  input  logic [8*(2**OFFSET_W)-1:0]     mem_data,
  input  logic                           inval,
  output logic [15:0]                    hit_cnt,
  output logic [15:0]                    miss_cnt
);

  localparam int BLK_W = 8 * (2**OFFSET_W);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]          state_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [OFFSET_W-1:0] off_reg;
  logic                write_reg;
  logic [7:0]          wdata_reg;
  logic                replay_reg;
  logic [WAY_W-1:0]    rr_ptr_reg;
  logic [WAYS-1:0]     valid_reg;
  logic [7:0]          rdata_reg;
  logic [15:0]         hit_cnt_reg;
  logic [15:0]         miss_cnt_reg;

  // Tag and data storage carry no reset; valid_reg alone qualifies them.
  logic [TAG_W-1:0]    tag_mem  [WAYS];
  logic [BLK_W-1:0]    data_mem [WAYS];

  logic [WAYS-1:0]     match;
  logic                hit_any;
  logic                all_valid;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim;
  logic [BLK_W-1:0]    hit_line;
  logic [7:0]          hit_byte;
  logic [OFFSET_W+2:0] bit_base;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (tag_mem[gi] == tag_reg);
    end
  endgenerate

  assign hit_any   = |match;
  assign all_valid = &valid_reg;
  assign bit_base  = {off_reg, 3'b000};

  // Tags are unique within the set, so the encoder sees at most one match.
  // The victim is the lowest invalid way, else the round-robin pointer.
  always_comb begin
    hit_way = '0;
    victim  = rr_ptr_reg;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) hit_way = WAY_W'(i);
      if (!valid_reg[i]) victim = WAY_W'(i);
    end
  end

  assign hit_line = data_mem[hit_way];
  assign hit_byte = hit_line[bit_base +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tag_reg      <= '0;
      off_reg      <= '0;
      write_reg    <= 1'b0;
      wdata_reg    <= '0;
      replay_reg   <= 1'b0;
      rr_ptr_reg   <= '0;
      valid_reg    <= '0;
      rdata_reg    <= '0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (inval) begin
            valid_reg <= '0;
          end else if (req_valid) begin
            tag_reg    <= req_tag;
            off_reg    <= req_offset;
            write_reg  <= req_write;
            wdata_reg  <= req_wdata;
            replay_reg <= 1'b0;
            state_reg  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            rdata_reg <= write_reg ? wdata_reg : hit_byte;
            // A replayed lookup follows a counted miss; do not count it twice.
            if (!replay_reg && hit_cnt_reg != 16'hFFFF)
              hit_cnt_reg <= hit_cnt_reg + 16'd1;
            state_reg <= RESP;
          end else begin
            replay_reg <= 1'b1;
            if (miss_cnt_reg != 16'hFFFF)
              miss_cnt_reg <= miss_cnt_reg + 16'd1;
            state_reg <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid_reg[victim] <= 1'b1;
            // The pointer only advances when it actually chose the victim.
            if (all_valid) rr_ptr_reg <= rr_ptr_reg + 1'b1;
            state_reg <= LOOKUP;
          end
        end
        RESP: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset forces IDLE asynchronously, so neither write fires while reset is low.
  always_ff @(posedge clk) begin
    if (state_reg == REFILL && mem_ack) begin
      tag_mem[victim]  <= tag_reg;
      data_mem[victim] <= mem_data;
    end else if (state_reg == LOOKUP && hit_any && write_reg) begin
      data_mem[hit_way][bit_base +: 8] <= wdata_reg;
    end
  end

  assign req_ready = (state_reg == IDLE) && !inval;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_hit   = (state_reg == RESP) && !replay_reg;
  assign rsp_rdata = rdata_reg;
  assign mem_req   = (state_reg == REFILL);
  assign mem_tag   = tag_reg;
  assign hit_cnt   = hit_cnt_reg;
  assign miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_cache_set_nway.sv
// Bench for cache_set_nway: a set-level model predicts hit/miss, data and
// counters per transaction; a monitor compares every response and refill
// request against the predictions, cycle-accurate on rsp_valid timing.
module tb_cache_set_nway;
  localparam int WAYS = 8;
  localparam int BLK_B = 32;

  logic        clk, reset, req_valid, req_write, req_ready;
  logic [23:0] req_tag, mem_tag;
  logic [4:0]  req_offset;
  logic [7:0]  req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_hit, mem_req, mem_ack, inval;
  logic [255:0] mem_data;
  logic [15:0] hit_cnt, miss_cnt;

  cache_set_nway #(.WAYS(WAYS), .TAG_W(24), .OFFSET_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_tag(req_tag), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_rdata(rsp_rdata), .mem_req(mem_req), .mem_tag(mem_tag),
    .mem_ack(mem_ack), .mem_data(mem_data), .inval(inval),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Next-level memory contents: a fixed function of tag and byte index.
  function automatic logic [7:0] blk_byte(input logic [23:0] t, input int k);
    return t[7:0] ^ t[15:8] ^ t[23:16] ^ 8'(k) ^ 8'h3F;
  endfunction

  // ---------------- set model ----------------
  logic        m_valid [WAYS];
  logic [23:0] m_tag   [WAYS];
  logic [7:0]  m_data  [WAYS][BLK_B];
  int m_rr, m_hits, m_misses, m_last_victim;

  task automatic model_reset();
    for (int i = 0; i < WAYS; i++) m_valid[i] = 1'b0;
    m_rr = 0; m_hits = 0; m_misses = 0; m_last_victim = -1;
  endtask

  task automatic model_access(input logic wr, input logic [23:0] tag, input logic [4:0] off,
                              input logic [7:0] wd, output logic hit, output logic [7:0] rd);
    int way;
    way = -1;
    for (int i = 0; i < WAYS; i++) if (m_valid[i] && m_tag[i] == tag) way = i;
    hit = (way >= 0);
    if (hit) begin
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_misses < 65535) m_misses++;
      for (int i = 0; i < WAYS; i++) if (!m_valid[i] && way < 0) way = i;
      if (way < 0) begin
        way = m_rr;
        m_rr = (m_rr + 1) % WAYS;
      end
      m_valid[way] = 1'b1;
      m_tag[way] = tag;
      for (int k = 0; k < BLK_B; k++) m_data[way][k] = blk_byte(tag, k);
      m_last_victim = way;
    end
    if (wr) begin
      m_data[way][off] = wd;
      rd = wd;
    end else begin
      rd = m_data[way][off];
    end
  endtask

  // ---------------- expectation queue + monitor ----------------
  typedef struct {
    logic [23:0] tag;
    logic        hit;
    logic [7:0]  rdata;
    int          due;
    logic [15:0] hc;
    logic [15:0] mc;
  } exp_t;
  exp_t exp_q[$];

  logic        last_hit;
  logic [7:0]  last_rdata;
  logic        seen_mem_req;
  logic [23:0] seen_mem_tag;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          checks++; failures++;
          $display("FAIL rsp_timing actual=rsp_valid@%0d required=none_or_later", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_hit", rsp_hit, e.hit);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("hit_cnt", hit_cnt, e.hc);
          chk("miss_cnt", miss_cnt, e.mc);
          last_hit = rsp_hit;
          last_rdata = rsp_rdata;
        end
      end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        checks++; failures++;
        $display("FAIL rsp_missing actual=0 required=rsp_valid@%0d", cyc);
        void'(exp_q.pop_front());
      end
      if (mem_req) begin
        seen_mem_req = 1'b1;
        seen_mem_tag = mem_tag;
        if (exp_q.size() == 0 || exp_q[0].hit) begin
          checks++; failures++;
          $display("FAIL mem_req_unexpected actual=1 required=0 tag=0x%0h", mem_tag);
        end else begin
          chk("mem_tag", mem_tag, exp_q[0].tag);
        end
      end
    end
  end

  // Next-level responder: acks after ack_delay_cfg REFILL cycles.
  int ack_delay_cfg = 0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= ack_delay_cfg) begin
        mem_ack = 1'b1;
        for (int k = 0; k < BLK_B; k++) mem_data[k*8 +: 8] = blk_byte(mem_tag, k);
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic start_req(input logic wr, input logic [23:0] tag, input logic [4:0] off,
                           input logic [7:0] wd, input int d);
    exp_t e;
    logic h;
    logic [7:0] rd;
    ack_delay_cfg = d;
    model_access(wr, tag, off, wd, h, rd);
    e.tag = tag; e.hit = h; e.rdata = rd;
    e.due = cyc + (h ? 2 : 4 + d);
    e.hc = 16'(m_hits); e.mc = 16'(m_misses);
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_tag = tag; req_offset = off; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic access(input logic wr, input logic [23:0] tag, input logic [4:0] off,
                        input logic [7:0] wd, input int d);
    int n;
    wait_ready();
    start_req(wr, tag, off, wd, d);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL access_timeout actual=pending required=done tag=0x%0h", tag);
      exp_q.delete();
    end
  endtask

  logic [23:0] fill_tag [8];

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_tag = '0; req_offset = '0;
    req_wdata = '0; inval = 1'b0; mem_ack = 1'b0; mem_data = '0;
    last_hit = 1'b0; last_rdata = '0; seen_mem_req = 1'b0; seen_mem_tag = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_tag", mem_tag, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // Cold load, ack after two wait cycles.
    access(1'b0, 24'h00ABCD, 5'd3, 8'h00, 2);
    chk("cold_hit", last_hit, 0);
    chk("cold_rdata", last_rdata, 8'h5A);
    chk("cold_mem_tag", seen_mem_tag, 24'h00ABCD);
    chk("cold_miss_cnt", miss_cnt, 1);
    chk("model_misses", m_misses, 1);

    // Repeat the load: hit, no refill.
    seen_mem_req = 1'b0;
    access(1'b0, 24'h00ABCD, 5'd3, 8'h00, 0);
    chk("warm_hit", last_hit, 1);
    chk("warm_rdata", last_rdata, 8'h5A);
    chk("warm_hit_cnt", hit_cnt, 1);
    chk("warm_no_mem_req", seen_mem_req, 0);

    // Store hit, then reload the same byte and a neighbour.
    access(1'b1, 24'h00ABCD, 5'd3, 8'hC3, 0);
    chk("store_rdata", last_rdata, 8'hC3);
    chk("store_hit", last_hit, 1);
    access(1'b0, 24'h00ABCD, 5'd3, 8'h00, 0);
    chk("reload_rdata", last_rdata, 8'hC3);
    access(1'b0, 24'h00ABCD, 5'd4, 8'h00, 0);
    chk("neighbour_rdata", last_rdata, 8'h5D);

    // Fill ways 1..7, then two more tags evict ways 0 and 1.
    for (int i = 1; i < 8; i++) begin
      fill_tag[i] = 24'h100000 + 24'(i) * 24'h001111;
      access(1'(i % 2), fill_tag[i], 5'(i), 8'(8'h40 + i), i % 3);
    end
    access(1'b0, 24'h900009, 5'd0, 8'h00, 1);
    chk("victim9_model", m_last_victim, 0);
    chk("victim9_hit", last_hit, 0);
    access(1'b0, 24'hA0000A, 5'd31, 8'h00, 0);
    chk("victim10_model", m_last_victim, 1);
    access(1'b0, 24'h00ABCD, 5'd3, 8'h00, 0);
    chk("evicted_first_hit", last_hit, 0);
    chk("evicted_first_rdata", last_rdata, 8'h5A);
    access(1'b0, fill_tag[3], 5'd3, 8'h00, 0);
    chk("way3_still_hit", last_hit, 1);
    access(1'b0, fill_tag[1], 5'd1, 8'h00, 0);
    chk("way1_evicted_hit", last_hit, 0);

    // Store miss allocates and writes on replay.
    access(1'b1, 24'hDEAD00, 5'd7, 8'h77, 1);
    chk("store_miss_hit", last_hit, 0);
    access(1'b0, 24'hDEAD00, 5'd7, 8'h00, 0);
    chk("store_miss_reload", last_rdata, 8'h77);

    // Invalidate; a simultaneous request must not be accepted.
    wait_ready();
    inval = 1'b1; req_valid = 1'b1; req_tag = 24'hDEAD00;
    #1;
    chk("inval_req_ready", req_ready, 0);
    @(negedge clk);
    inval = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < WAYS; i++) m_valid[i] = 1'b0;
    access(1'b0, 24'hDEAD00, 5'd7, 8'h00, 0);
    chk("post_inval_hit", last_hit, 0);

    // Reset in the middle of a refill.
    wait_ready();
    start_req(1'b0, 24'h00ABCD, 5'd3, 8'h00, 1000);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("midrefill_mem_req_up", mem_req, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrefill_mem_req", mem_req, 0);
    chk("midrefill_hit_cnt", hit_cnt, 0);
    chk("midrefill_miss_cnt", miss_cnt, 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1'b0, fill_tag[3], 5'd3, 8'h00, 1);
    chk("after_reset_hit", last_hit, 0);
    chk("after_reset_miss_cnt", miss_cnt, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_set_nway.md
CACHE_SET_NWAY -- requirements
Module: cache_set_nway

Interface
REQ-001 SHALL have parameter WAYS, default 8, number of ways in the set (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 24, tag width in bits.
REQ-003 SHALL have parameter OFFSET_W, default 5, byte-offset width; block = 2^OFFSET_W bytes (BLK_W = 8*2^OFFSET_W bits).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  access request present.
REQ-007 SHALL have port req_write  input  1  1 = byte store, 0 = byte load.
REQ-008 SHALL have port req_tag  input  TAG_W  request tag.
REQ-009 SHALL have port req_offset  input  OFFSET_W  byte offset within block.
REQ-010 SHALL have port req_wdata  input  8  store byte.
REQ-011 SHALL have port req_ready  output  1  request accepted this cycle.
REQ-012 SHALL have port rsp_valid  output  1  response valid, one-cycle pulse.
REQ-013 SHALL have port rsp_hit  output  1  1 = served without refill.
REQ-014 SHALL have port rsp_rdata  output  8  loaded byte, or stored byte for a store.
REQ-015 SHALL have port mem_req  output  1  refill request to next level.
REQ-016 SHALL have port mem_tag  output  TAG_W  tag being refilled.
REQ-017 SHALL have port mem_ack  input  1  refill data valid this cycle.
REQ-018 SHALL have port mem_data  input  BLK_W  refill block, byte 0 in bits [7:0].
REQ-019 SHALL have port inval  input  1  invalidate all ways.
REQ-020 SHALL have ports hit_cnt, miss_cnt  output  16 each  saturating event counters.

Function
REQ-021 SHALL implement FSM states IDLE, LOOKUP, REFILL, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE with inval=0 (combinational).
REQ-023 IDLE: req_valid & req_ready SHALL register tag/offset/write/wdata and go to LOOKUP; clear a replay flag.
REQ-024 IDLE with inval=1 SHALL clear every valid bit at the next edge and stay in IDLE; inval outside IDLE ignored.
REQ-025 LOOKUP: hit = any way with valid=1 and stored tag == registered tag; at most one way SHALL match.
REQ-026 LOOKUP hit: load SHALL register matching byte into rsp_rdata; store SHALL write byte into matching way at that edge and register req_wdata into rsp_rdata; go to RESP.
REQ-027 LOOKUP miss: SHALL go to REFILL, set replay flag, increment miss_cnt.
REQ-028 LOOKUP hit with replay flag clear SHALL increment hit_cnt; replayed lookups SHALL not count.
REQ-029 REFILL: mem_req SHALL be 1 and mem_tag = registered tag, held stable until mem_ack.
REQ-030 REFILL with mem_ack=1: SHALL write mem_data, tag and valid=1 into the victim way, go to LOOKUP (replay, guaranteed hit).
REQ-031 Victim SHALL be the lowest-index invalid way; if all valid, the way at a round-robin pointer, which then increments modulo WAYS.
REQ-032 RESP: rsp_valid=1 for exactly one cycle, rsp_hit = NOT replay flag; then IDLE.
REQ-033 Hit latency SHALL be 2 cycles accept-to-rsp_valid; miss latency = 4 + cycles waiting for mem_ack.
REQ-034 mem_ack outside REFILL SHALL be ignored.
REQ-035 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-036 Store miss SHALL allocate (refill then write byte on replay); no dirty tracking, write-through handled upstream.

Reset
REQ-037 reset=0 SHALL asynchronously force IDLE, all valid bits 0, round-robin pointer 0, replay flag 0, counters 0, rsp_valid 0, rsp_hit 0, rsp_rdata 0, mem_req 0, mem_tag 0.
REQ-038 Reset during REFILL SHALL drop mem_req immediately; no way written; tag/data arrays need no reset.

Verification
REQ-039 Cold load tag 0x00ABCD off 3, mem_ack after 2 cycles with byte3=0x5A -> mem_req with mem_tag 0x00ABCD, rsp_valid rsp_hit=0 rdata 0x5A, miss_cnt=1.
REQ-040 Repeat same load -> rsp_valid 2 cycles after accept, rsp_hit=1, rdata 0x5A, hit_cnt=1, no mem_req.
REQ-041 Store 0xC3 to offset 3 on hit, then load offset 3 -> rsp_rdata 0xC3 both times, rsp_hit=1.
REQ-042 Fill 8 distinct tags into ways 0..7, then 9th and 10th tags miss -> victims way 0 then way 1; first tag then misses.
REQ-043 inval pulse in IDLE, then reload any cached tag -> miss, req_ready 0 during inval cycle.
REQ-044 reset low mid-REFILL -> mem_req 0 same cycle, counters 0, prior tag misses after release.
